// File: rtl/data_ram_responder.sv
// data_ram_responder
//   Responder end of the CPU data-memory port. Word-organised RAM with
//   synchronous byte-lane writes and a combinational read, so a load
//   completes in the cycle it is presented. Write select patterns and
//   address range are validated; the first illegal access is recorded in
//   sticky error status.
//
//   Optional feature (macro DATA_RAM_CLEAR_EN): a CLEAR/READY sequencer
//   zeroes every word after reset and holds ready low while it runs.
//   Without the macro, ready is tied high and contents persist over reset.
//
// Ports:
//   clock          system clock, rising edge
//   reset          synchronous, active-high
//   read_enable    load request
//   read_address   load byte address (bits [1:0] ignored for indexing)
//   read_data      word at read_address, 0 when not a valid read
//   write_enable   store request
//   write_address  store byte address (bits [1:0] ignored for indexing)
//   write_select   byte-lane enables, bit3 = [31:24], bit0 = [7:0]
//   write_data     lane-aligned store data
//   ready          array accepting accesses
//   error          sticky illegal-access flag
//   error_address  byte address of the first illegal access
module data_ram_responder #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        read_enable,
  input  logic [31:0] read_address,
  output logic [31:0] read_data,
  input  logic        write_enable,
  input  logic [31:0] write_address,
  input  logic [3:0]  write_select,
  input  logic [31:0] write_data,
  output logic        ready,
  output logic        error,
  output logic [31:0] error_address
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [31:0] mem [0:DEPTH-1];

  logic [ADDR_WIDTH-1:0] read_index;
  logic [ADDR_WIDTH-1:0] write_index;
  logic                  read_out_of_range;
  logic                  write_out_of_range;
  logic                  select_legal;
  logic                  read_illegal;
  logic                  write_illegal;
  logic                  write_ok;

  assign read_index         = read_address[ADDR_WIDTH+1:2];
  assign write_index        = write_address[ADDR_WIDTH+1:2];
  assign read_out_of_range  = |read_address[31:ADDR_WIDTH+2];
  assign write_out_of_range = |write_address[31:ADDR_WIDTH+2];

  always_comb begin
    select_legal = 1'b0;
    case (write_select)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: select_legal = 1'b1;
      default:                   select_legal = 1'b0;
    endcase
  end

  assign read_illegal  = ready && read_enable && read_out_of_range;
  assign write_illegal = ready && write_enable && (write_out_of_range || !select_legal);
  assign write_ok      = ready && write_enable && !write_out_of_range && select_legal;

  // Combinational read sees pre-write contents on a same-cycle collision.
  assign read_data = (read_enable && ready && !read_out_of_range) ? mem[read_index] : '0;

`ifdef DATA_RAM_CLEAR_EN
  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] clear_count;
  logic                  clearing;

  assign ready    = (state == ST_READY);
  assign clearing = (state == ST_CLEAR) && !reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_CLEAR;
      clear_count <= '0;
    end else if (state == ST_CLEAR) begin
      clear_count <= clear_count + 1'b1;
      if (clear_count == '1) state <= ST_READY;
    end
  end

  always_ff @(posedge clock) begin
    if (clearing) begin
      mem[clear_count] <= '0;
    end else if (write_ok) begin
      for (int unsigned i = 0; i < 4; i++)
        if (write_select[i]) mem[write_index][8*i +: 8] <= write_data[8*i +: 8];
    end
  end
`else
  assign ready = 1'b1;

  always_ff @(posedge clock) begin
    if (write_ok) begin
      for (int unsigned i = 0; i < 4; i++)
        if (write_select[i]) mem[write_index][8*i +: 8] <= write_data[8*i +: 8];
    end
  end
`endif

  // Only the first illegal access is recorded; the write address wins
  // when both ports are illegal in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      error         <= 1'b0;
      error_address <= '0;
    end else if (!error) begin
      if (write_illegal) begin
        error         <= 1'b1;
        error_address <= write_address;
      end else if (read_illegal) begin
        error         <= 1'b1;
        error_address <= read_address;
      end
    end
  end

endmodule

// File: tb/tb_data_ram_responder.sv
// Directed self-checking bench for data_ram_responder. Uses ADDR_WIDTH=4
// when DATA_RAM_CLEAR_EN is defined (short clear sequence), 10 otherwise.
module tb_data_ram_responder;

`ifdef DATA_RAM_CLEAR_EN
  localparam int AW = 4;
`else
  localparam int AW = 10;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        read_enable = 1'b0;
  logic [31:0] read_address = '0;
  logic [31:0] read_data;
  logic        write_enable = 1'b0;
  logic [31:0] write_address = '0;
  logic [3:0]  write_select = '0;
  logic [31:0] write_data = '0;
  logic        ready;
  logic        error;
  logic [31:0] error_address;

  int checks = 0;
  int errors = 0;

  data_ram_responder #(.ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset(reset),
    .read_enable(read_enable), .read_address(read_address), .read_data(read_data),
    .write_enable(write_enable), .write_address(write_address),
    .write_select(write_select), .write_data(write_data),
    .ready(ready), .error(error), .error_address(error_address)
  );

  always #5 clock = ~clock;

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("FAIL %s observed %h expected %h", tag, observed, expected);
      end
  endtask

  task automatic drive(input logic re, input logic [31:0] ra, input logic we,
                       input logic [31:0] wa, input logic [3:0] ws, input logic [31:0] wd);
    read_enable = re; read_address = ra;
    write_enable = we; write_address = wa; write_select = ws; write_data = wd;
    #1;
  endtask

  task automatic idle;
    drive(1'b0, '0, 1'b0, '0, 4'b0000, '0);
  endtask

  task automatic write_word(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    drive(1'b0, '0, 1'b1, a, s, d);
    step;
    idle;
  endtask

  task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] expected);
    drive(1'b1, a, 1'b0, '0, 4'b0000, '0);
    check(tag, read_data, expected);
    idle;
  endtask

`ifdef DATA_RAM_CLEAR_EN
  // Counts cycles with ready low, bounded so a stuck sequencer cannot hang the run.
  task automatic count_clear(output int n);
    n = 0;
    while (!ready && n < 200) begin
      n++;
      step;
    end
  endtask
`endif

  initial begin
    int n;
    idle;
    step;
    step;
    check("reset_error", {31'b0, error}, 32'h0);
    check("reset_error_address", error_address, 32'h0);
    reset = 1'b0;
`ifdef DATA_RAM_CLEAR_EN
    check("reset_ready_low", {31'b0, ready}, 32'h0);
    count_clear(n);
    check("clear_cycles", n, 32'd16);
    check("ready_after_clear", {31'b0, ready}, 32'h1);
`else
    check("reset_ready_high", {31'b0, ready}, 32'h1);
`endif

    // Full-word write then read
    write_word(32'h10, 4'b1111, 32'hDEAD_BEEF);
    read_check("full_word_read", 32'h10, 32'hDEAD_BEEF);
    check("no_error_after_write", {31'b0, error}, 32'h0);

    // Byte-lane merge, low address bits ignored
    write_word(32'h10, 4'b0010, 32'h0000_AA00);
    read_check("lane_merge", 32'h13, 32'hDEAD_AAEF);

    // Same-cycle read/write collision
    write_word(32'h20, 4'b1111, 32'h1111_1111);
    drive(1'b1, 32'h20, 1'b1, 32'h20, 4'b1111, 32'h2222_2222);
    check("collision_old", read_data, 32'h1111_1111);
    step;
    drive(1'b1, 32'h20, 1'b0, '0, 4'b0000, '0);
    check("collision_new", read_data, 32'h2222_2222);
    read_enable = 1'b0;
    #1;
    check("read_disabled_zero", read_data, 32'h0);

    // Half-word and byte selects
    write_word(32'h20, 4'b1100, 32'hAABB_0000);
    write_word(32'h20, 4'b0001, 32'h0000_00CC);
    read_check("half_and_byte", 32'h20, 32'hAABB_22CC);

    // Illegal accesses
    write_word(32'h0, 4'b1111, 32'h5555_5555);
    write_word(32'h4, 4'b1111, 32'h7777_7777);
    check("error_still_clear", {31'b0, error}, 32'h0);
    write_word(32'h1000, 4'b1111, 32'h1234_5678);
    check("oor_write_error", {31'b0, error}, 32'h1);
    check("oor_write_address", error_address, 32'h1000);
    read_check("oor_write_no_alias", 32'h0, 32'h5555_5555);
    write_word(32'h4, 4'b0101, 32'hFFFF_FFFF);
    read_check("bad_select_suppressed", 32'h4, 32'h7777_7777);
    check("error_address_sticky", error_address, 32'h1000);
    write_word(32'h4, 4'b0000, 32'hFFFF_FFFF);
    read_check("zero_select_suppressed", 32'h4, 32'h7777_7777);
    read_check("oor_read_zero", 32'h1000, 32'h0);
    check("error_address_still_sticky", error_address, 32'h1000);

    // Reset clears error; simultaneous illegal read+write captures write address
    reset = 1'b1;
    step;
    reset = 1'b0;
    check("reset_clears_error", {31'b0, error}, 32'h0);
    check("reset_clears_address", error_address, 32'h0);
`ifdef DATA_RAM_CLEAR_EN
    count_clear(n);
    check("clear_cycles_2", n, 32'd16);
    for (int unsigned w = 0; w < 16; w++)
      read_check("cleared_word", 32'(w * 4), 32'h0);
`else
    read_check("persist_over_reset", 32'h10, 32'hDEAD_AAEF);
`endif
    drive(1'b1, 32'h2000, 1'b1, 32'h3000, 4'b1111, 32'h0);
    step;
    idle;
    check("both_illegal_error", {31'b0, error}, 32'h1);
    check("both_illegal_write_wins", error_address, 32'h3000);

    // Illegal read alone
    reset = 1'b1;
    step;
    reset = 1'b0;
`ifdef DATA_RAM_CLEAR_EN
    count_clear(n);
`endif
    drive(1'b1, 32'h4006, 1'b0, '0, 4'b0000, '0);
    step;
    idle;
    check("oor_read_error", {31'b0, error}, 32'h1);
    check("oor_read_address", error_address, 32'h4006);

`ifdef DATA_RAM_CLEAR_EN
    // Reset mid-clear restarts the count; accesses during clear are ignored
    write_word(32'h8, 4'b1111, 32'h1234_5678);
    reset = 1'b1;
    step;
    reset = 1'b0;
    for (int i = 0; i < 7; i++) step;
    reset = 1'b1;
    step;
    reset = 1'b0;
    check("midclear_ready_low", {31'b0, ready}, 32'h0);
    drive(1'b1, 32'h4000, 1'b1, 32'h8, 4'b1111, 32'hFFFF_FFFF);
    step;
    idle;
    n = 0;
    while (!ready && n < 200) begin
      n++;
      step;
    end
    check("midclear_cycles", n, 32'd15);
    read_check("clear_write_ignored", 32'h8, 32'h0);
    check("clear_no_error", {31'b0, error}, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/data_ram_responder.md
Name: data_ram_responder

Overview:
- Responder end of the CPU data-memory port: services the read, write, byte-select and write-data requests issued by the MEM stage.
- Word-organised synchronous-write / combinational-read RAM, so a load completes in the same cycle it is presented, as the MEM stage requires.
- Validates write byte-select patterns and address range, and reports violations through sticky error status.
- Optional power-up clear sequencer zeroes the array after reset.

Parameters:
ADDR_WIDTH, 10, word-index width; depth = 2^ADDR_WIDTH 32-bit words; byte address range 0 .. 2^(ADDR_WIDTH+2)-1

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
read_enable  input  1  load request this cycle
read_address  input  32  byte address of load; bits [1:0] ignored for indexing
read_data  output  32  word at read_address (combinational)
write_enable  input  1  store request this cycle
write_address  input  32  byte address of store; bits [1:0] ignored for indexing
write_select  input  4  byte-lane enables; bit3 = [31:24], bit0 = [7:0]
write_data  input  32  store data, lane-aligned
ready  output  1  1 = array accepting accesses
error  output  1  sticky: illegal access seen since reset
error_address  output  32  byte address of first illegal access

Behaviour:
- Clock and reset: one clock (clock); reset is synchronous and active-high (reset).
- Reset values:
  - error = 0, error_address = 0.
  - ready = 0 with DATA_RAM_CLEAR_EN, 1 without it.
  - Array contents are untouched by reset unless the clear feature runs.
- Index and range:
  - Word index = address[ADDR_WIDTH+1:2].
  - Out of range = any of address[31:ADDR_WIDTH+2] nonzero.
- Read path (combinational, zero latency):
  - read_data = mem[index] when read_enable && ready && in range; otherwise 0.
- Write path:
  - At the rising edge, when write_enable && ready && in range && select legal, each lane i with write_select[i]=1 takes write_data[8i+7:8i].
  - Other lanes hold their value.
- Legal select patterns: 4'b0001, 0010, 0100, 1000, 0011, 1100, 1111.
  - Any other pattern with write_enable=1 (including 0000) is illegal: the write is suppressed.
- Same-cycle read and write to the same word: read_data returns pre-write contents; new data is visible from the next cycle.
- Error capture:
  - An illegal access is an out-of-range read (read_enable=1), an out-of-range write, or an illegal select.
  - On the first illegal access since reset, error goes to 1 at the next edge and error_address latches the offending byte address.
  - Later illegal accesses do not change error_address. Only reset clears error.
  - If read and write are both illegal in the same cycle, the write address is captured.
  - Accesses while ready=0 are ignored and never flag errors.
- Sequencer states (with DATA_RAM_CLEAR_EN):
  - CLEAR: counter starts at 0; each cycle writes 32'h0 to mem[counter], counter++.
    - When counter == 2^ADDR_WIDTH-1 and that word is written: move to READY next edge.
    - ready=0 throughout CLEAR.
  - READY: ready=1; normal operation.
  - Reset in any state (including mid-CLEAR): returns to CLEAR with counter = 0, error and error_address = 0.
  - CLEAR duration is exactly 2^ADDR_WIDTH cycles after reset deasserts; ready rises on the following cycle.
- No internal stall is produced; one access of each kind per cycle is sustained indefinitely.

Optional Feature:
- Macro: DATA_RAM_CLEAR_EN.
- Defined: CLEAR/READY sequencer present; array is zero after every reset; ready is low for 2^ADDR_WIDTH cycles.
- Undefined: no sequencer or counter; ready is tied to 1; array contents persist across reset (initial contents are simulation-undefined); all other behaviour is identical.

Test Plan:
- Full-word write then read: write 0x0000_0010 data 0xDEAD_BEEF sel 1111; next cycle read 0x10 -> read_data 0xDEAD_BEEF; error stays 0.
- Byte-lane merge: prior word 0xDEAD_BEEF; write 0x10 data 0x0000_AA00 sel 0010 -> read 0x13 returns 0xDEAD_AAEF (bits [1:0] ignored).
- Same-cycle read and write to 0x20 (old 0x1111_1111, new 0x2222_2222 sel 1111) -> read_data 0x1111_1111 that cycle, 0x2222_2222 next cycle.
- Illegal accesses with ADDR_WIDTH=10:
  - Write to 0x0000_1000 sel 1111 -> no array change; error=1 next cycle; error_address=0x1000.
  - Then write sel 0101 to 0x4 -> suppressed; error_address stays 0x1000.
- Clear sequence (macro on, ADDR_WIDTH=4): preload nonzero; pulse reset 1 cycle -> ready=0 for 16 cycles, then 1; all 16 words read 0.
  - Reassert reset at cycle 7 -> count restarts; ready rises 16 cycles after the second release.
- Access during CLEAR: write 0x8 data 0xFFFF_FFFF sel 1111 while ready=0 -> ignored; word reads 0 after ready; error=0.
